fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch and T-state sequencer that sits directly downstream of the program counter. It uses the PC value as the fetch address and latches the returned word into the instruction register. It pulses the PC increment input once per instruction and counts execution T-states for the microcode decoder. It is the only block that drives the PC's inc input.

Parameters:
WIDTH, 16, data and address width; matches the PC.
T_BITS, 3, width of the T-state counter.
MAX_T, 8, T-state count at which an instruction is forcibly ended (tstate never exceeds MAX_T-1).

Ports:
clk  input  1  system clock; all state changes on the posedge.
reset  input  1  asynchronous, active-high; clears all state immediately.
pc_value  input  WIDTH  current PC value from the PC block.
mem_rdata  input  WIDTH  memory read data.
mem_ready  input  1  memory handshake; read data is valid in the cycle it is high.
instr_end  input  1  from microcode: current T-state is the last one of this instruction.
halt  input  1  stop request; sampled only at an instruction boundary.
mem_addr  output  WIDTH  fetch address.
mem_req  output  1  fetch request.
pc_inc  output  1  increment strobe to the PC.
ir  output  WIDTH  instruction register.
ir_valid  output  1  ir holds the instruction currently executing.
tstate  output  T_BITS  current T-state.
halted  output  1  sequencer is stopped.

Behaviour:
- States: FETCH (tstate=0), INC (tstate=1), EXEC (tstate 2..MAX_T-1), HALT.
- Reset asserted: state=FETCH, tstate=0, ir=0, ir_valid=0, halted=0. During reset, pc_inc=0 and mem_req=0.
- Reset is honoured mid-instruction and mid-handshake; the partially fetched word is discarded.
- mem_addr = pc_value at all times (combinational pass-through).
- mem_req = (state==FETCH) && !reset. Moore output; it is high in the first cycle after reset deasserts.
- FETCH, mem_ready=0: hold state; ir, ir_valid and tstate unchanged. There is no timeout.
- FETCH, mem_ready=1 at posedge: ir<=mem_rdata, ir_valid<=1, tstate<=1, go to INC.
- INC: pc_inc=1 for exactly this one cycle (pc_inc = state==INC). The PC increments at the posedge that ends INC. Next: tstate<=2, go to EXEC.
- EXEC: at each posedge:
  - if instr_end=1 or tstate==MAX_T-1: instruction ends;
  - otherwise tstate<=tstate+1.
- Instruction end: ir_valid<=0 and tstate<=0; ir keeps its old value.
  - halt=1 at that posedge: go to HALT.
  - halt=0: go to FETCH.
- instr_end is ignored in FETCH, INC and HALT.
- halt is ignored except at an instruction end. It does not pre-empt a fetch or an executing instruction.
- mem_ready is ignored outside FETCH.
- HALT: halted=1, mem_req=0, pc_inc=0, tstate=0. Left only via reset.
- Minimum instruction length is 3 cycles: zero-wait FETCH, INC, one EXEC cycle. Maximum is (wait cycles) + MAX_T.
- tstate never wraps through an unused value. After MAX_T-1 the next value is 0.
- pc_inc is never high in two consecutive cycles.
- pc_value must be stable while mem_req is high; the sequencer does not re-sample it.

Test Plan:
1. Hold pc_value=1500 and mem_rdata=16'h1234; assert reset mid-EXEC with tstate=4 -> immediately tstate=0, ir=0, ir_valid=0, pc_inc=0, mem_req=0. Release reset -> mem_req=1, mem_addr=1500.
2. Zero-wait fetch: pc_value=1500, mem_ready=1, mem_rdata=16'h1234 -> after edge 1: ir=16'h1234, ir_valid=1, tstate=1, pc_inc=1. After edge 2: pc_inc=0, tstate=2. A connected PC reads 1501.
3. Wait states: mem_ready low for 3 posedges -> mem_req stays 1, tstate=0, ir unchanged. mem_ready=1 on the 4th posedge -> ir latched, tstate=1.
4. instr_end=1 while tstate=3 -> next cycle tstate=0, ir_valid=0, mem_req=1, and mem_addr equals the incremented PC.
5. Forced end: instr_end held 0 -> tstate runs 2,3,4,5,6,7 and then 0. The next fetch starts and exactly one pc_inc pulse occurs per instruction.
6. Halt: halt=1 raised at tstate=2, instr_end=1 at tstate=4 -> tstate continues to 4. At that edge: halted=1, mem_req=0, tstate=0, held for 20 cycles with pc_inc=0. Reset -> halted=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch and T-state sequencer sitting directly downstream of the
//   program counter. It fetches the word at the current PC and latches it into
//   the instruction register. It pulses the PC increment strobe once per
//   instruction. It then counts execution T-states for the microcode decoder
//   until the instruction ends.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      asynchronous, active-high; clears all state immediately
//   pc_value   current PC value (used as the fetch address)
//   mem_rdata  memory read data, valid while mem_ready is high
//   mem_ready  memory handshake for the outstanding fetch
//   instr_end  microcode: current T-state is the last of the instruction
//   halt       stop request, only honoured at an instruction end
//   mem_addr   fetch address (pass-through of pc_value)
//   mem_req    fetch request, high while in FETCH
//   pc_inc     one-cycle increment strobe to the PC
//   ir         instruction register
//   ir_valid   ir holds the instruction currently executing
//   tstate     current T-state
//   halted     sequencer is stopped (left only via reset)
module fetch_sequencer #(
    parameter int WIDTH  = 16,
    parameter int T_BITS = 3,
    parameter int MAX_T  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  pc_value,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ready,
    input  logic              instr_end,
    input  logic              halt,
    output logic [WIDTH-1:0]  mem_addr,
    output logic              mem_req,
    output logic              pc_inc,
    output logic [WIDTH-1:0]  ir,
    output logic              ir_valid,
    output logic [T_BITS-1:0] tstate,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        INC   = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Last legal T-state; reaching it forces the instruction to end.
    localparam logic [T_BITS-1:0] T_LAST = T_BITS'(MAX_T - 1);
    localparam logic [T_BITS-1:0] T_ZERO = '0;
    localparam logic [T_BITS-1:0] T_ONE  = T_BITS'(1);
    localparam logic [T_BITS-1:0] T_TWO  = T_BITS'(2);

    state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            tstate   <= T_ZERO;
            ir       <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // Wait indefinitely for memory; nothing changes until ready.
                    if (mem_ready) begin
                        ir       <= mem_rdata;
                        ir_valid <= 1'b1;
                        tstate   <= T_ONE;
                        state    <= INC;
                    end
                end
                INC: begin
                    tstate <= T_TWO;
                    state  <= EXEC;
                end
                EXEC: begin
                    if (instr_end || (tstate == T_LAST)) begin
                        // ir keeps the finished instruction for observation.
                        ir_valid <= 1'b0;
                        tstate   <= T_ZERO;
                        if (halt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state  <= FETCH;
                        end
                    end else begin
                        tstate <= tstate + T_ONE;
                    end
                end
                HALT: begin
                    tstate <= T_ZERO;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= FETCH;
                    tstate <= T_ZERO;
                end
            endcase
        end
    end

    // Strobes are gated by reset so they drop the moment reset is raised.
    assign mem_addr = pc_value;
    assign mem_req  = (state == FETCH) && !reset;
    assign pc_inc   = (state == INC) && !reset;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer with a simple loadable PC model
// that increments on pc_inc.
module tb_fetch_sequencer;

    localparam int WIDTH  = 16;
    localparam int T_BITS = 3;
    localparam int MAX_T  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [WIDTH-1:0]  pc_value;
    logic [WIDTH-1:0]  mem_rdata;
    logic              mem_ready;
    logic              instr_end;
    logic              halt;
    logic [WIDTH-1:0]  mem_addr;
    logic              mem_req;
    logic              pc_inc;
    logic [WIDTH-1:0]  ir;
    logic              ir_valid;
    logic [T_BITS-1:0] tstate;
    logic              halted;

    // PC model
    logic [WIDTH-1:0]  pc_reg;
    logic              pc_load;
    logic [WIDTH-1:0]  pc_load_val;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_load)     pc_reg <= pc_load_val;
        else if (pc_inc) pc_reg <= pc_reg + 16'd1;
    end
    assign pc_value = pc_reg;

    fetch_sequencer #(.WIDTH(WIDTH), .T_BITS(T_BITS), .MAX_T(MAX_T)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_value  (pc_value),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .instr_end (instr_end),
        .halt      (halt),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .pc_inc    (pc_inc),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .tstate    (tstate),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 16'd1500;
        mem_rdata   = 16'h1234;
        mem_ready   = 1'b0;
        instr_end   = 1'b0;
        halt        = 1'b0;
        step();
        step();
        // Reset state
        check("rst_mem_req",  mem_req,  0);
        check("rst_pc_inc",   pc_inc,   0);
        check("rst_tstate",   tstate,   0);
        check("rst_ir",       ir,       0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_halted",   halted,   0);

        reset   = 1'b0;
        pc_load = 1'b0;
        #1;
        check("rel_mem_req",  mem_req,  1);
        check("rel_mem_addr", mem_addr, 1500);

        // Zero-wait fetch
        mem_ready = 1'b1;
        step();
        check("zw_ir",       ir,       16'h1234);
        check("zw_ir_valid", ir_valid, 1);
        check("zw_tstate",   tstate,   1);
        check("zw_pc_inc",   pc_inc,   1);
        check("zw_mem_req",  mem_req,  0);
        mem_ready = 1'b0;
        step();
        check("zw_pc_inc_off", pc_inc,   0);
        check("zw_tstate2",    tstate,   2);
        check("zw_pc_next",    mem_addr, 1501);
        step();
        check("zw_tstate3", tstate, 3);
        step();
        check("zw_tstate4", tstate, 4);

        // Asynchronous reset mid-EXEC
        #2;
        reset       = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = 16'd1500;
        #1;
        check("ar_tstate",   tstate,   0);
        check("ar_ir",       ir,       0);
        check("ar_ir_valid", ir_valid, 0);
        check("ar_pc_inc",   pc_inc,   0);
        check("ar_mem_req",  mem_req,  0);
        step();
        reset   = 1'b0;
        pc_load = 1'b0;
        #1;
        check("ar_rel_mem_req",  mem_req,  1);
        check("ar_rel_mem_addr", mem_addr, 1500);

        // Wait states: read data present but not ready
        mem_rdata = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ws_mem_req", mem_req, 1);
            check("ws_tstate",  tstate,  0);
            check("ws_ir",      ir,      0);
            check("ws_pc_inc",  pc_inc,  0);
        end
        mem_rdata = 16'hABCD;
        mem_ready = 1'b1;
        step();
        check("ws_ir_latch", ir,     16'hABCD);
        check("ws_tstate1",  tstate, 1);
        check("ws_pc_inc1",  pc_inc, 1);
        mem_ready = 1'b0;

        // instr_end at tstate 3
        step();
        check("ie_tstate2", tstate, 2);
        step();
        check("ie_tstate3", tstate, 3);
        instr_end = 1'b1;
        step();
        instr_end = 1'b0;
        check("ie_tstate0",   tstate,   0);
        check("ie_ir_valid",  ir_valid, 0);
        check("ie_mem_req",   mem_req,  1);
        check("ie_mem_addr",  mem_addr, 1501);
        check("ie_ir_kept",   ir,       16'hABCD);

        // Forced end at MAX_T-1
        mem_rdata = 16'h5555;
        mem_ready = 1'b1;
        pulses    = 0;
        step();
        if (pc_inc) pulses++;
        check("fe_tstate1", tstate, 1);
        mem_ready = 1'b0;
        for (int t = 2; t <= 7; t++) begin
            step();
            if (pc_inc) pulses++;
            check("fe_tstate", tstate, t);
        end
        step();
        if (pc_inc) pulses++;
        check("fe_wrap",      tstate,   0);
        check("fe_ir_valid",  ir_valid, 0);
        check("fe_mem_req",   mem_req,  1);
        check("fe_mem_addr",  mem_addr, 1502);
        check("fe_pulses",    pulses,   1);

        // Halt only at instruction end
        mem_rdata = 16'h7777;
        mem_ready = 1'b1;
        step();
        check("h_tstate1", tstate, 1);
        mem_ready = 1'b0;
        step();
        check("h_tstate2", tstate, 2);
        halt = 1'b1;
        step();
        check("h_tstate3", tstate, 3);
        check("h_not_yet", halted, 0);
        step();
        check("h_tstate4", tstate, 4);
        instr_end = 1'b1;
        step();
        instr_end = 1'b0;
        halt      = 1'b0;
        mem_ready = 1'b1;
        check("h_halted",   halted,   1);
        check("h_mem_req",  mem_req,  0);
        check("h_tstate0",  tstate,   0);
        check("h_ir_valid", ir_valid, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (pc_inc) pulses++;
            check("h_hold_halted", halted,  1);
            check("h_hold_req",    mem_req, 0);
            check("h_hold_tstate", tstate,  0);
        end
        check("h_no_pulses", pulses, 0);
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("h_rst_halted",  halted,  0);
        check("h_rst_mem_req", mem_req, 0);
        step();
        reset = 1'b0;
        #1;
        check("h_rel_mem_req", mem_req, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
